md_sched: RTL and testbench

- Multi-cycle multiply/divide scheduler for the execute stage of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E stage and owns the HI/LO registers.
- Sequences each mult/div over a fixed cycle count and raises busy so the hazard logic stalls any following md instruction or MFHI/MFLO.
- Operands are GPR values, or immediates already extended upstream.

---
 rtl/mips_defs.sv | 26 ++
 rtl/md_alu.sv | 62 ++++++
 rtl/md_sched.sv | 96 +++++++++
 tb/tb_md_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the multiply/divide unit: op encodings,
// default sequencing lengths and the scheduler state type.
package mips_defs;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Encoding 0 is "no op" and 7 is reserved; everything in between is real.
  function automatic logic is_md_op(logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath. Produces the {hi,lo} pair for
// the latched op and flags a zero divisor so the scheduler can keep HI/LO.
module md_alu
  import mips_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [31:0] b_safe;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        div_ovf;

  // A zero divisor is replaced by 1 so the dividers never see x-producing
  // input; the result is discarded in that case anyway.
  assign b_safe  = (b == 32'd0) ? 32'd1 : b;
  // The only signed quotient that does not fit in 32 bits.
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Arithmetic for all four mult/div flavours.
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    quo_u  = a / b_safe;
    rem_u  = a % b_safe;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end else begin
      quo_s = $signed(a) / $signed(b_safe);
      rem_s = $signed(a) % $signed(b_safe);
    end
  end

  // Select the result pair for the op.
  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        result   = {rem_s, quo_s};
        div_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        result   = {rem_u, quo_u};
        div_zero = (b == 32'd0);
      end
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler owning HI/LO.
//
// state | meaning
// IDLE  | ready; accepts MTHI/MTLO (single cycle) or starts a mult/div
// RUN   | counting down a mult/div; HI/LO written when counter hits 0
module md_sched
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  md_state_t   state;
  logic [CW-1:0] counter;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] alu_result;
  logic        alu_div_zero;
  logic        accept;

  assign accept = start && !cancel && (state == ST_IDLE) && is_md_op(md_op);

  md_alu u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (alu_result),
    .div_zero (alu_div_zero)
  );

  // FSM, countdown timer, latched operands and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      counter <= '0;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (md_op)
              MD_MTHI: hi <= rs_data;
              MD_MTLO: lo <= rs_data;
              default: begin
                op_q    <= md_op;
                a_q     <= rs_data;
                b_q     <= rt_data;
                counter <= ((md_op == MD_MULT) || (md_op == MD_MULTU)) ?
                           CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                state   <= ST_RUN;
                busy    <= 1'b1;
              end
            endcase
          end
        end
        ST_RUN: begin
          if (counter == '0) begin
            if (!alu_div_zero) begin
              hi <= alu_result[63:32];
              lo <= alu_result[31:0];
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched with a cycle-level reference model.
module tb_md_sched;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .cancel  (cancel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: remaining busy cycles plus a pending result.
  int          m_rem;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_res;
  bit          m_dz;

  function automatic logic [64:0] model_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); return {1'b0, p}; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      3'd3: begin
        if (b == 0) return {1'b1, 64'd0};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, 64'd0};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [64:0] cr;
    if (reset) begin
      m_rem = 0; m_hi = 0; m_lo = 0; m_res = 0; m_dz = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && !m_dz) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
      end
    end else if (start && !cancel && md_op >= 3'd1 && md_op <= 3'd6) begin
      if (md_op == 3'd5) m_hi = rs_data;
      else if (md_op == 3'd6) m_lo = rs_data;
      else begin
        cr    = model_calc(md_op, rs_data, rt_data);
        m_dz  = cr[64];
        m_res = cr[63:0];
        m_rem = (md_op <= 3'd2) ? MC : DC;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b; cancel = c;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; cancel = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  int cnt;

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_data = 0; rt_data = 0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;

    issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0);
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(cnt);
    check("mult_cycles", cnt, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(cnt);
    check("multu_cycles", cnt, 32'd5);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(cnt);
    check("div_cycles", cnt, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(cnt);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    issue(3'd4, 32'd100, 32'd7, 1'b0);
    wait_idle(cnt);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    issue(3'd5, 32'h55, 32'd0, 1'b0);
    issue(3'd6, 32'h55, 32'd0, 1'b0);
    issue(3'd4, 32'd100, 32'd0, 1'b0);
    wait_idle(cnt);
    check("divz_cycles", cnt, 32'd10);
    check("divz_hi", hi, 32'h55);
    check("divz_lo", lo, 32'h55);

    issue(3'd1, 32'd3, 32'd4, 1'b1);
    check("cancel_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("cancel_hi", hi, 32'h55);
    check("cancel_lo", lo, 32'h55);

    issue(3'd7, 32'd9, 32'd9, 1'b0);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_lo", lo, 32'h55);

    // Accepted MULT with an MTLO start and a cancel arriving mid-run.
    issue(3'd1, 32'd3, 32'd4, 1'b0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      if (cnt == 1) begin
        start = 1'b1; md_op = 3'd6; rs_data = 32'd99;
      end else if (cnt == 2) begin
        start = 1'b0; md_op = 3'd0; cancel = 1'b1;
      end else begin
        cancel = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    cancel = 1'b0;
    check("mid_cycles", cnt, 32'd5);
    check("mid_hi", hi, 32'd0);
    check("mid_lo", lo, 32'd12);

    // Asynchronous reset during busy cycle 4 of a DIV.
    issue(3'd3, 32'd1000, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_hi", hi, 32'd0);
    check("async_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(3'd6, 32'd7, 32'd0, 1'b0);
    check("post_rst_lo", lo, 32'd7);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
